// File: rtl/fetch_cache_pkg.sv
// Shared widths, FSM encoding and default geometry for the fetch_cache block.
// Optional feature macro: FETCH_CACHE_EN (see fetch_cache.sv).
package fetch_cache_pkg;

    localparam int PC_W           = 32;
    localparam int INSTR_W        = 32;
    localparam int WADDR_W        = PC_W - 2;
    localparam int DEF_INDEX_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MISS  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_cache_array.sv
// Line storage for fetch_cache: combinational read port, single write port.
// FETCH_CACHE_EN selects full direct-mapped arrays; otherwise a one-entry bypass register.
module fetch_cache_array
    import fetch_cache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WADDR_W-1:0] i_rd_waddr,
    output logic               o_rd_match,
    output logic [INSTR_W-1:0] o_rd_data,
    input  logic               i_wr_en,
    input  logic [WADDR_W-1:0] i_wr_waddr,
    input  logic [INSTR_W-1:0] i_wr_data,
    input  logic               i_inval
);

`ifdef FETCH_CACHE_EN
    localparam int TAG_BITS = WADDR_W - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [INSTR_W-1:0]    r_data [LINES];
    logic [INDEX_BITS-1:0] w_rd_idx;
    logic [INDEX_BITS-1:0] w_wr_idx;
    logic [TAG_BITS-1:0]   w_rd_tag;
    logic [TAG_BITS-1:0]   w_wr_tag;
    logic                  w_unused_inval;

    assign w_rd_idx       = i_rd_waddr[INDEX_BITS-1:0];
    assign w_rd_tag       = i_rd_waddr[WADDR_W-1:INDEX_BITS];
    assign w_wr_idx       = i_wr_waddr[INDEX_BITS-1:0];
    assign w_wr_tag       = i_wr_waddr[WADDR_W-1:INDEX_BITS];
    // Lines are only ever replaced, never invalidated individually.
    assign w_unused_inval = i_inval;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    // Tag/data carry no reset; valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[w_wr_idx]  <= w_wr_tag;
            r_data[w_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_match = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign o_rd_data  = r_data[w_rd_idx];
`else
    logic                  r_valid;
    logic [WADDR_W-1:0]    r_waddr;
    logic [INSTR_W-1:0]    r_data;
    logic [INDEX_BITS-1:0] w_unused_idx;

    assign w_unused_idx = i_rd_waddr[INDEX_BITS-1:0];

    // A fill always wins; the entry is dropped after one hit or any flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_waddr <= '0;
            r_data  <= '0;
        end else if (i_wr_en) begin
            r_valid <= 1'b1;
            r_waddr <= i_wr_waddr;
            r_data  <= i_wr_data;
        end else if (i_inval) begin
            r_valid <= 1'b0;
        end
    end

    assign o_rd_match = r_valid && (r_waddr == i_rd_waddr);
    assign o_rd_data  = r_data;
`endif

endmodule

// File: rtl/fetch_cache.sv
// Direct-mapped instruction cache / fetch engine between IQ and memory controller.
// Build macro FETCH_CACHE_EN enables the line arrays; without it only a one-word bypass exists.
module fetch_cache
    import fetch_cache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc_from_iq,
    output logic [INSTR_W-1:0] instr_to_iq,
    output logic               is_hit_to_iq,
    input  logic               is_exception_from_rob,
    output logic               req_to_mc,
    output logic [PC_W-1:0]    addr_to_mc,
    input  logic [INSTR_W-1:0] instr_from_mc,
    input  logic               is_ready_from_mc,
    output state_t             o_dbg_state
);

    state_t             r_state;
    state_t             w_next_state;
    logic [WADDR_W-1:0] r_miss_waddr;
    logic               w_rd_match;
    logic [INSTR_W-1:0] w_rd_data;
    logic               w_hit;
    logic               w_start_miss;
    logic               w_fill;
    logic [1:0]         w_unused_pc_lsb;

    assign w_unused_pc_lsb = pc_from_iq[1:0];

    fetch_cache_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_waddr (pc_from_iq[PC_W-1:2]),
        .o_rd_match (w_rd_match),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_fill),
        .i_wr_waddr (r_miss_waddr),
        .i_wr_data  (instr_from_mc),
        .i_inval    (w_hit || is_exception_from_rob)
    );

    assign w_hit        = w_rd_match && (r_state == ST_IDLE) && !is_exception_from_rob;
    assign is_hit_to_iq = w_hit;
    assign instr_to_iq  = w_hit ? w_rd_data : '0;

    // MC handshake: req_to_mc stays high with a stable addr_to_mc from the cycle after the miss
    // until the cycle is_ready_from_mc strobes; that strobe both delivers the word and retires the request.
    assign req_to_mc   = (r_state != ST_IDLE);
    assign addr_to_mc  = {r_miss_waddr, 2'b00};
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_miss_waddr <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start_miss) begin
                r_miss_waddr <= pc_from_iq[PC_W-1:2];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start_miss = 1'b0;
        w_fill       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // w_hit already folds in the exception, so this is "lookup miss, no flush".
                if (!w_hit && !is_exception_from_rob) begin
                    w_start_miss = 1'b1;
                    w_next_state = ST_MISS;
                end
            end
            ST_MISS: begin
                if (is_ready_from_mc) begin
                    w_fill       = !is_exception_from_rob;
                    w_next_state = ST_IDLE;
                end else if (is_exception_from_rob) begin
                    w_next_state = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (is_ready_from_mc) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_cache.sv
// Self-checking bench for fetch_cache: per-cycle vector table plus a reset-mid-miss sequence.
module tb_fetch_cache;
    import fetch_cache_pkg::*;

    localparam logic [1:0] S_I = 2'd0;
    localparam logic [1:0] S_M = 2'd1;
    localparam logic [1:0] S_A = 2'd2;

    typedef struct packed {
        logic        hit;
        logic [31:0] instr;
        logic        req;
        logic [31:0] addr;
        logic [1:0]  st;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic        exc;
        logic        rdy;
        logic [31:0] mc_data;
        exp_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_from_iq;
    logic [31:0] instr_to_iq;
    logic        is_hit_to_iq;
    logic        is_exception_from_rob;
    logic        req_to_mc;
    logic [31:0] addr_to_mc;
    logic [31:0] instr_from_mc;
    logic        is_ready_from_mc;
    state_t      dbg_state;

    vec_t        tbl[$];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] d1, d2, d3, d4, d5, d6, d7, d8, d9;

    fetch_cache dut (
        .clk                   (clk),
        .rst                   (rst),
        .pc_from_iq            (pc_from_iq),
        .instr_to_iq           (instr_to_iq),
        .is_hit_to_iq          (is_hit_to_iq),
        .is_exception_from_rob (is_exception_from_rob),
        .req_to_mc             (req_to_mc),
        .addr_to_mc            (addr_to_mc),
        .instr_from_mc         (instr_from_mc),
        .is_ready_from_mc      (is_ready_from_mc),
        .o_dbg_state           (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    endtask

    task automatic row(input logic [31:0] pc, input logic exc, input logic rdy, input logic [31:0] d,
                       input logic hit, input logic [31:0] instr, input logic req,
                       input logic [31:0] addr, input logic [1:0] st);
        vec_t v;
        v.pc        = pc;
        v.exc       = exc;
        v.rdy       = rdy;
        v.mc_data   = d;
        v.exp.hit   = hit;
        v.exp.instr = instr;
        v.exp.req   = req;
        v.exp.addr  = addr;
        v.exp.st    = st;
        tbl.push_back(v);
    endtask

    // Called just after a posedge: drive, compare at the negedge, advance one cycle.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        pc_from_iq            = v.pc;
        is_exception_from_rob = v.exc;
        is_ready_from_mc      = v.rdy;
        instr_from_mc         = v.mc_data;
        exp_q.push_back(v.exp);
        @(negedge clk);
        e = exp_q.pop_front();
        check($sformatf("row%0d hit", idx), {31'b0, is_hit_to_iq}, {31'b0, e.hit});
        check($sformatf("row%0d instr", idx), instr_to_iq, e.instr);
        check($sformatf("row%0d req", idx), {31'b0, req_to_mc}, {31'b0, e.req});
        check($sformatf("row%0d state", idx), {30'b0, dbg_state}, {30'b0, e.st});
        if (e.req) check($sformatf("row%0d addr", idx), addr_to_mc, e.addr);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        d1 = $urandom; d2 = $urandom; d3 = $urandom; d4 = $urandom; d5 = $urandom;
        d6 = $urandom; d7 = $urandom; d8 = $urandom; d9 = $urandom_range(32'hFFFF, 1);

        // Cold miss on 0x1000, MC answers one cycle after the request appears.
        row(32'h1000, 0, 0, 0,           0, 0,            0, 0,           S_I);
        row(32'h1000, 0, 0, 0,           0, 0,            1, 32'h1000,    S_M);
        row(32'h1000, 0, 1, 32'h93,      0, 0,            1, 32'h1000,    S_M);
        row(32'h1000, 0, 0, 0,           1, 32'h93,       0, 0,           S_I);
`ifdef FETCH_CACHE_EN
        // Sequential fills with zero MC latency; one fill returns while pc has moved on.
        row(32'h1004, 0, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h1004, 0, 1, d1,          0, 0,  1, 32'h1004, S_M);
        row(32'h1004, 0, 0, 0,           1, d1, 0, 0,        S_I);
        row(32'h1008, 0, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h2000, 0, 1, d2,          0, 0,  1, 32'h1008, S_M);
        row(32'h1008, 0, 0, 0,           1, d2, 0, 0,        S_I);
        row(32'h100C, 0, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h100C, 0, 1, d3,          0, 0,  1, 32'h100C, S_M);
        row(32'h100C, 0, 0, 0,           1, d3, 0, 0,        S_I);
        row(32'h1000, 0, 0, 0,           1, 32'h93, 0, 0,    S_I);
        row(32'h1004, 0, 0, 0,           1, d1, 0, 0,        S_I);
        row(32'h1008, 0, 0, 0,           1, d2, 0, 0,        S_I);
        // Alias on index 0: 0x1400 evicts 0x1000.
        row(32'h1400, 0, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h1400, 0, 1, d4,          0, 0,  1, 32'h1400, S_M);
        row(32'h1400, 0, 0, 0,           1, d4, 0, 0,        S_I);
        row(32'h1000, 0, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h1000, 0, 1, 32'h93,      0, 0,  1, 32'h1000, S_M);
        row(32'h1000, 0, 0, 0,           1, 32'h93, 0, 0,    S_I);
        row(32'h1004, 0, 0, 0,           1, d1, 0, 0,        S_I);
        // Flush in IDLE hides a resident line and starts nothing.
        row(32'h1000, 1, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h1000, 0, 0, 0,           1, 32'h93, 0, 0,    S_I);
`else
        // Bypass: consumed after one hit, so a second fetch goes back to the MC.
        row(32'h1000, 0, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h1000, 0, 1, 32'h93,      0, 0,  1, 32'h1000, S_M);
        row(32'h1000, 0, 0, 0,           1, 32'h93, 0, 0,    S_I);
        // Bypass hits only on a matching address; fill uses the latched miss address.
        row(32'h1004, 0, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h2000, 0, 1, d1,          0, 0,  1, 32'h1004, S_M);
        row(32'h2000, 0, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h2000, 0, 1, d2,          0, 0,  1, 32'h2000, S_M);
        row(32'h2000, 0, 0, 0,           1, d2, 0, 0,        S_I);
        row(32'h1004, 0, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h1004, 0, 1, d1,          0, 0,  1, 32'h1004, S_M);
        row(32'h1004, 0, 0, 0,           1, d1, 0, 0,        S_I);
        // A flush drops a pending bypass entry.
        row(32'h1008, 0, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h1008, 0, 1, d3,          0, 0,  1, 32'h1008, S_M);
        row(32'h1008, 1, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h1008, 0, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h1008, 0, 1, d3,          0, 0,  1, 32'h1008, S_M);
        row(32'h1008, 0, 0, 0,           1, d3, 0, 0,        S_I);
`endif
        // Flush mid-miss: ABORT holds the request (also through a second flush), word dropped.
        row(32'h3010, 0, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h3010, 1, 0, 0,           0, 0,  1, 32'h3010, S_M);
        row(32'h3010, 1, 0, 0,           0, 0,  1, 32'h3010, S_A);
        row(32'h3010, 0, 1, d5,          0, 0,  1, 32'h3010, S_A);
        row(32'h3014, 0, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h3014, 0, 1, d6,          0, 0,  1, 32'h3014, S_M);
        row(32'h3014, 0, 0, 0,           1, d6, 0, 0,        S_I);
        row(32'h3010, 0, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h3010, 0, 1, d7,          0, 0,  1, 32'h3010, S_M);
        row(32'h3010, 0, 0, 0,           1, d7, 0, 0,        S_I);
        // Flush coincident with the MC strobe: no fill, straight back to IDLE.
        row(32'h4020, 0, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h4020, 1, 1, d8,          0, 0,  1, 32'h4020, S_M);
`ifdef FETCH_CACHE_EN
        row(32'h1000, 0, 0, 0,           1, 32'h93, 0, 0,    S_I);
`endif
        row(32'h4020, 0, 0, 0,           0, 0,  0, 0,        S_I);
        row(32'h4020, 0, 1, d9,          0, 0,  1, 32'h4020, S_M);
        row(32'h4020, 0, 0, 0,           1, d9, 0, 0,        S_I);

        // ---------- reset and table ----------
        rst                   = 1'b1;
        pc_from_iq            = 32'h1000;
        is_exception_from_rob = 1'b0;
        is_ready_from_mc      = 1'b0;
        instr_from_mc         = '0;
        @(negedge clk);
        check("reset hit", {31'b0, is_hit_to_iq}, 32'd0);
        check("reset instr", instr_to_iq, 32'd0);
        check("reset req", {31'b0, req_to_mc}, 32'd0);
        check("reset addr", addr_to_mc, 32'd0);
        check("reset state", {30'b0, dbg_state}, {30'b0, S_I});
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
        check("queue drained", exp_q.size(), 32'd0);

        // ---------- reset in the middle of a miss ----------
        pc_from_iq = 32'h5000;
        @(negedge clk);
        check("rmiss start state", {30'b0, dbg_state}, {30'b0, S_I});
        @(posedge clk);
        #1;
        check("rmiss req", {31'b0, req_to_mc}, 32'd1);
        check("rmiss addr", addr_to_mc, 32'h5000);
        #2;
        rst = 1'b1;
        #1;
        check("rmiss req dropped", {31'b0, req_to_mc}, 32'd0);
        check("rmiss addr cleared", addr_to_mc, 32'd0);
        check("rmiss state", {30'b0, dbg_state}, {30'b0, S_I});
        @(posedge clk);
        #1;
        rst        = 1'b0;
        pc_from_iq = 32'h1000;
        @(negedge clk);
        check("post-reset hit (valid cleared)", {31'b0, is_hit_to_iq}, 32'd0);
        @(posedge clk);
        #1;
        check("post-reset req", {31'b0, req_to_mc}, 32'd1);
        check("post-reset addr", addr_to_mc, 32'h1000);
        is_ready_from_mc = 1'b1;
        instr_from_mc    = 32'h77;
        @(posedge clk);
        #1;
        is_ready_from_mc = 1'b0;
        instr_from_mc    = '0;
        @(negedge clk);
        check("post-reset refill hit", {31'b0, is_hit_to_iq}, 32'd1);
        check("post-reset refill instr", instr_to_iq, 32'h77);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
